ifu_redirect_ctrl: RTL
======================

IFU_REDIRECT_CTRL -- requirements
Module: ifu_redirect_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter width.
REQ-002 SHALL have parameter CNT_W, default 16, redirect-statistics counter width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 exc_redirect_valid / exc_redirect_pc  in  1 / PC_W  exception or interrupt redirect.
REQ-007 bk_redirect_valid / bk_redirect_pc  in  1 / PC_W  backend branch-mispredict redirect.
REQ-008 bpu_redirect_valid / bpu_redirect_pc  in  1 / PC_W  IF3 predicted-taken redirect.
REQ-009 icache_busy  in  1  iCache has an outstanding refill that cannot be cancelled.
REQ-010 icache_pause_req / if23_pause_req / ibuf_pause_req  in  1 each  stage pause requests.
REQ-011 pc_update_valid / pc_update_pc  out  1 / PC_W  load new fetch PC into IF0.
REQ-012 flush_if0_1, flush_if2_3, flush_icache, flush_if3, flush_ibuf  out  1 each  per-stage flush.
REQ-013 pause_if0_1, pause_if2_3, pause_icache, pause_if3, pause_ibuf_out  out  1 each  per-stage pause.
REQ-014 redirect_cnt  out  CNT_W  saturating count of accepted backend/exception redirects.
REQ-015 draining  out  1  high while state is DRAIN.

Function
REQ-016 SHALL implement states RUN, DRAIN, RESUME.
REQ-017 SHALL select redirects by fixed priority: exc > bk > bpu; only the winner is accepted that cycle.
REQ-018 In RUN, an accepted exc/bk redirect SHALL, in the next cycle, assert all five flush outputs for exactly one cycle.
REQ-019 In RUN, an accepted exc/bk redirect with icache_busy=0 SHALL assert pc_update_valid with its PC in the next cycle (1-cycle latency); state stays RUN.
REQ-020 In RUN, an accepted exc/bk redirect with icache_busy=1 SHALL latch the PC into pending_pc and enter DRAIN.
REQ-021 In DRAIN, pause_if0_1 SHALL be high and pc_update_valid low.
REQ-022 In DRAIN, a new exc/bk redirect SHALL overwrite pending_pc, re-flush all stages the next cycle and remain in DRAIN.
REQ-023 In DRAIN, bpu redirects SHALL be ignored.
REQ-024 In DRAIN, the first cycle with icache_busy=0 and no new exc/bk redirect SHALL transition to RESUME.
REQ-025 RESUME SHALL assert pc_update_valid with pending_pc for one cycle and return to RUN.
REQ-026 RESUME SHALL accept exc/bk redirects as in RUN; the newer PC wins and pending_pc is discarded.
REQ-027 In RUN with no exc/bk redirect, an accepted bpu redirect SHALL flush only flush_if0_1 and flush_if2_3 and assert pc_update_valid with bpu_redirect_pc, both in the next cycle.
REQ-028 Flush and pc_update outputs SHALL be registered; pause outputs SHALL be combinational.
REQ-029 pause_if2_3, pause_icache, pause_if3 and pause_ibuf_out SHALL each equal ibuf_pause_req.
REQ-030 pause_if0_1 = icache_pause_req | if23_pause_req | ibuf_pause_req | (state==DRAIN).
REQ-031 Pauses SHALL NOT block flushes or pc_update; flush has precedence over pause in all stages.
REQ-032 redirect_cnt SHALL increment by 1 per accepted exc/bk redirect and saturate at all-ones.

Reset
REQ-033 On rst: state=RUN; pending_pc=0; redirect_cnt=0; all flush outputs 0; pc_update_valid=0; pc_update_pc=0.
REQ-034 Reset SHALL dominate any same-cycle redirect; a redirect asserted while rst=1 is dropped.
REQ-035 Reset mid-DRAIN SHALL discard pending_pc without issuing pc_update.

Structure
REQ-036 The state enum (RUN/DRAIN/RESUME) and the flush-mask typedef (5 bits, one per stage) SHALL live in the shared front-end package.
REQ-037 The priority selector SHALL be a sub-module redirect_arbiter (combinational, 3 requesters to winner valid/pc/is_backend).

Verification
REQ-038 bk_redirect pc=0x80001000, icache_busy=0 -> next cycle all flushes=1 and pc_update 0x80001000; redirect_cnt=1.
REQ-039 exc pc=0xBFC00380 and bk pc=0x1234 in the same cycle -> pc_update 0xBFC00380 only; redirect_cnt=1.
REQ-040 bk pc=0x100 with icache_busy=1 for 4 cycles -> draining=1 and pause_if0_1=1 for 4 cycles; RESUME then issues pc_update 0x100 once.
REQ-041 During DRAIN, bk pc=0x200, then bpu pc=0x300 -> pending_pc=0x200, bpu ignored; final pc_update is 0x200.
REQ-042 bpu pc=0x400 in RUN with ibuf_pause_req=1 -> flush_if0_1/if2_3=1 and flush_ibuf=0; pc_update 0x400; all five pauses high.
REQ-043 rst asserted in DRAIN -> next cycle state RUN and all outputs 0; no pc_update afterwards.

Source files
------------

// File: rtl/ifu_redirect_ctrl_pkg.sv
// ifu_redirect_ctrl_pkg
//   Shared front-end types for the fetch-unit redirect controller:
//   - state_e      : redirect FSM states (RUN / DRAIN / RESUME)
//   - flush_mask_t : one flush bit per front-end stage
//   - flush mask constants for a full-pipe and a front-only flush
package ifu_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RESUME = 2'd2
  } state_e;

  typedef struct packed {
    logic if0_1;
    logic if2_3;
    logic icache;
    logic if3;
    logic ibuf;
  } flush_mask_t;

  localparam flush_mask_t FLUSH_NONE  = flush_mask_t'(5'b00000);
  localparam flush_mask_t FLUSH_ALL   = flush_mask_t'(5'b11111);
  // A predicted-taken redirect from IF3 only invalidates the younger stages.
  localparam flush_mask_t FLUSH_FRONT = flush_mask_t'(5'b11000);

endpackage

// File: rtl/ifu_redirect_ctrl_arbiter.sv
// redirect_arbiter
//   Combinational fixed-priority selector: exc > bk > bpu.
//   Ports:
//     exc_valid/exc_pc, bk_valid/bk_pc, bpu_valid/bpu_pc : requesters
//     win_valid      : some requester is active
//     win_pc         : PC of the highest-priority active requester
//     win_is_backend : winner is exc or bk (full flush, counted)
module redirect_arbiter #(
  parameter int PC_W = 32
) (
  input  logic            exc_valid,
  input  logic [PC_W-1:0] exc_pc,
  input  logic            bk_valid,
  input  logic [PC_W-1:0] bk_pc,
  input  logic            bpu_valid,
  input  logic [PC_W-1:0] bpu_pc,
  output logic            win_valid,
  output logic [PC_W-1:0] win_pc,
  output logic            win_is_backend
);

  always_comb begin
    win_valid      = 1'b0;
    win_pc         = '0;
    win_is_backend = 1'b0;
    if (exc_valid) begin
      win_valid      = 1'b1;
      win_pc         = exc_pc;
      win_is_backend = 1'b1;
    end else if (bk_valid) begin
      win_valid      = 1'b1;
      win_pc         = bk_pc;
      win_is_backend = 1'b1;
    end else if (bpu_valid) begin
      win_valid      = 1'b1;
      win_pc         = bpu_pc;
    end
  end

endmodule

// File: rtl/ifu_redirect_ctrl.sv
// ifu_redirect_ctrl
//   Fetch-unit redirect controller. Arbitrates exception, backend-mispredict
//   and BPU redirects, issues registered per-stage flushes and a registered
//   PC update to IF0, and holds IF0 in DRAIN while an uncancellable iCache
//   refill is outstanding.
//   Ports:
//     clk, rst                        : clock, synchronous active-high reset
//     exc_/bk_/bpu_redirect_valid/pc  : redirect requests
//     icache_busy                     : refill in flight, cannot be cancelled
//     *_pause_req                     : stage pause requests
//     pc_update_valid/pc              : load new fetch PC (registered)
//     flush_*                         : per-stage flushes (registered)
//     pause_*                         : per-stage pauses (combinational)
//     redirect_cnt                    : saturating count of exc/bk redirects
//     draining                        : state is DRAIN
//     dbg_state                       : current FSM state
//
//   Handshake: every *_valid here is a single-cycle pulse with no ready.
//   A redirect is taken on the edge where its valid is high and it wins
//   arbitration; losers are dropped, not held, so requesters must re-assert.
module ifu_redirect_ctrl
  import ifu_redirect_ctrl_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exc_redirect_valid,
  input  logic [PC_W-1:0]  exc_redirect_pc,
  input  logic             bk_redirect_valid,
  input  logic [PC_W-1:0]  bk_redirect_pc,
  input  logic             bpu_redirect_valid,
  input  logic [PC_W-1:0]  bpu_redirect_pc,
  input  logic             icache_busy,
  input  logic             icache_pause_req,
  input  logic             if23_pause_req,
  input  logic             ibuf_pause_req,
  output logic             pc_update_valid,
  output logic [PC_W-1:0]  pc_update_pc,
  output logic             flush_if0_1,
  output logic             flush_if2_3,
  output logic             flush_icache,
  output logic             flush_if3,
  output logic             flush_ibuf,
  output logic             pause_if0_1,
  output logic             pause_if2_3,
  output logic             pause_icache,
  output logic             pause_if3,
  output logic             pause_ibuf_out,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic             draining,
  output state_e           dbg_state
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pending_pc_q, pending_pc_d;
  flush_mask_t       flush_q, flush_d;
  logic              pcu_valid_q, pcu_valid_d;
  logic [PC_W-1:0]   pcu_pc_q, pcu_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              win_valid;
  logic [PC_W-1:0]   win_pc;
  logic              win_is_backend;
  logic              take_backend;

  redirect_arbiter #(.PC_W(PC_W)) u_arb (
    .exc_valid      (exc_redirect_valid),
    .exc_pc         (exc_redirect_pc),
    .bk_valid       (bk_redirect_valid),
    .bk_pc          (bk_redirect_pc),
    .bpu_valid      (bpu_redirect_valid),
    .bpu_pc         (bpu_redirect_pc),
    .win_valid      (win_valid),
    .win_pc         (win_pc),
    .win_is_backend (win_is_backend)
  );

  assign take_backend = win_valid & win_is_backend;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (take_backend && icache_busy) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A fresh backend redirect restarts the drain even if the refill
        // just finished; only a quiet, non-busy cycle lets us resume.
        if (!take_backend && !icache_busy) state_d = ST_RESUME;
      end
      ST_RESUME: begin
        if (take_backend && icache_busy) state_d = ST_DRAIN;
        else                             state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Registered-output / datapath next values
  always_comb begin
    pending_pc_d = pending_pc_q;
    flush_d      = FLUSH_NONE;
    pcu_valid_d  = 1'b0;
    pcu_pc_d     = pcu_pc_q;
    cnt_d        = cnt_q;

    if (take_backend) begin
      flush_d = FLUSH_ALL;
      if (cnt_q != '1) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    case (state_q)
      ST_RUN, ST_RESUME: begin
        if (take_backend) begin
          if (icache_busy) begin
            pending_pc_d = win_pc;
          end else begin
            pcu_valid_d = 1'b1;
            pcu_pc_d    = win_pc;
          end
        end else if (state_q == ST_RESUME) begin
          // The drained redirect is finally released to IF0; a BPU
          // redirect here targets a path that is about to be replaced.
          pcu_valid_d = 1'b1;
          pcu_pc_d    = pending_pc_q;
        end else if (win_valid) begin
          flush_d     = FLUSH_FRONT;
          pcu_valid_d = 1'b1;
          pcu_pc_d    = win_pc;
        end
      end
      ST_DRAIN: begin
        if (take_backend) pending_pc_d = win_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_pc_q <= '0;
      flush_q      <= FLUSH_NONE;
      pcu_valid_q  <= 1'b0;
      pcu_pc_q     <= '0;
      cnt_q        <= '0;
    end else begin
      pending_pc_q <= pending_pc_d;
      flush_q      <= flush_d;
      pcu_valid_q  <= pcu_valid_d;
      pcu_pc_q     <= pcu_pc_d;
      cnt_q        <= cnt_d;
    end
  end

  // Outputs: registered flush / pc_update, combinational pauses. Pauses only
  // stall stages; a flush on the same stage still takes effect.
  always_comb begin
    pc_update_valid = pcu_valid_q;
    pc_update_pc    = pcu_pc_q;
    flush_if0_1     = flush_q.if0_1;
    flush_if2_3     = flush_q.if2_3;
    flush_icache    = flush_q.icache;
    flush_if3       = flush_q.if3;
    flush_ibuf      = flush_q.ibuf;
    pause_if2_3     = ibuf_pause_req;
    pause_icache    = ibuf_pause_req;
    pause_if3       = ibuf_pause_req;
    pause_ibuf_out  = ibuf_pause_req;
    pause_if0_1     = icache_pause_req | if23_pause_req | ibuf_pause_req |
                      (state_q == ST_DRAIN);
    redirect_cnt    = cnt_q;
    draining        = (state_q == ST_DRAIN);
    dbg_state       = state_q;
  end

endmodule
